// File: rtl/hazard_stall_unit.sv
// Load-use / branch-flush / mul-div freeze sequencer for the ID/EX control path.
// Control outputs are combinational from state and inputs; only state, mdCnt and stallCount are registered.
module hazard_stall_unit #(
    parameter int MD_LATENCY  = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             idreg1,
    input  logic [3:0]             idreg2,
    input  logic                   idUse1,
    input  logic                   idUse2,
    input  logic [3:0]             exRegDest,
    input  logic [1:0]             exW,
    input  logic                   exMemRead,
    input  logic                   branchTaken,
    input  logic                   mdStart,
    input  logic                   stallClr,
    output logic                   pcWrite,
    output logic                   ifidWrite,
    output logic                   ifidFlush,
    output logic                   idexWrite,
    output logic                   idexBubble,
    output logic                   exmemBubble,
    output logic                   mdBusy,
    output logic                   mdDone,
    output logic [STALL_CNT_W-1:0] stallCount
);

    typedef enum logic {RUN, MD_BUSY} state_e;

    // The mdStart cycle is the first freeze cycle, so the countdown starts two short.
    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 2);

    state_e                 state_q, state_d;
    logic [7:0]             md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use;

    assign load_use = exMemRead && exW[0] &&
                      ((idUse1 && (idreg1 == exRegDest)) ||
                       (idUse2 && (idreg2 == exRegDest)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (!branchTaken && mdStart) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_INIT;
                end
            end
            default: begin
                if (md_cnt_q != 8'd0) begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexWrite   = 1'b1;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        mdBusy      = 1'b0;
        mdDone      = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (branchTaken) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (mdStart) begin
                        pcWrite     = 1'b0;
                        ifidWrite   = 1'b0;
                        idexWrite   = 1'b0;
                        exmemBubble = 1'b1;
                        mdBusy      = 1'b1;
                    end else if (load_use) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                    end
                end
                default: begin
                    // Same mul/div still occupies EX: branch, start and load-use are ignored.
                    if (md_cnt_q != 8'd0) begin
                        pcWrite     = 1'b0;
                        ifidWrite   = 1'b0;
                        idexWrite   = 1'b0;
                        exmemBubble = 1'b1;
                        mdBusy      = 1'b1;
                    end else begin
                        mdDone = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallClr) begin
            stall_cnt_d = '0;
        end else if (!pcWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Three DUT copies on shared stimulus (MD_LATENCY 8/2, narrow 4-bit counter) checked against a cycle model.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] idreg1, idreg2, exRegDest;
    logic       idUse1, idUse2, exMemRead, branchTaken, mdStart, stallClr;
    logic [1:0] exW;

    logic [7:0]  ctl [3];
    logic [15:0] sc  [3];
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;
    logic pw0, iw0, fl0, xw0, xb0, mb0, bz0, dn0;
    logic pw1, iw1, fl1, xw1, xb1, mb1, bz1, dn1;
    logic pw2, iw2, fl2, xw2, xb2, mb2, bz2, dn2;

    int n_cmp  = 0;
    int n_fail = 0;

    int lat  [3] = '{8, 2, 8};
    int maxc [3] = '{65535, 65535, 15};
    int left [3];
    int cnt  [3];
    bit epw  [3];

    always #5 clk = ~clk;

    hazard_stall_unit #(.MD_LATENCY(8), .STALL_CNT_W(16)) u_l8 (
        .clk(clk), .rst_n(rst_n), .idreg1(idreg1), .idreg2(idreg2), .idUse1(idUse1), .idUse2(idUse2),
        .exRegDest(exRegDest), .exW(exW), .exMemRead(exMemRead), .branchTaken(branchTaken),
        .mdStart(mdStart), .stallClr(stallClr), .pcWrite(pw0), .ifidWrite(iw0), .ifidFlush(fl0),
        .idexWrite(xw0), .idexBubble(xb0), .exmemBubble(mb0), .mdBusy(bz0), .mdDone(dn0),
        .stallCount(sc0));

    hazard_stall_unit #(.MD_LATENCY(2), .STALL_CNT_W(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .idreg1(idreg1), .idreg2(idreg2), .idUse1(idUse1), .idUse2(idUse2),
        .exRegDest(exRegDest), .exW(exW), .exMemRead(exMemRead), .branchTaken(branchTaken),
        .mdStart(mdStart), .stallClr(stallClr), .pcWrite(pw1), .ifidWrite(iw1), .ifidFlush(fl1),
        .idexWrite(xw1), .idexBubble(xb1), .exmemBubble(mb1), .mdBusy(bz1), .mdDone(dn1),
        .stallCount(sc1));

    hazard_stall_unit #(.MD_LATENCY(8), .STALL_CNT_W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .idreg1(idreg1), .idreg2(idreg2), .idUse1(idUse1), .idUse2(idUse2),
        .exRegDest(exRegDest), .exW(exW), .exMemRead(exMemRead), .branchTaken(branchTaken),
        .mdStart(mdStart), .stallClr(stallClr), .pcWrite(pw2), .ifidWrite(iw2), .ifidFlush(fl2),
        .idexWrite(xw2), .idexBubble(xb2), .exmemBubble(mb2), .mdBusy(bz2), .mdDone(dn2),
        .stallCount(sc2));

    assign ctl[0] = {pw0, iw0, fl0, xw0, xb0, mb0, bz0, dn0};
    assign ctl[1] = {pw1, iw1, fl1, xw1, xb1, mb1, bz1, dn1};
    assign ctl[2] = {pw2, iw2, fl2, xw2, xb2, mb2, bz2, dn2};
    assign sc[0]  = sc0;
    assign sc[1]  = sc1;
    assign sc[2]  = {12'd0, sc2};

    // Bit order: pcWrite ifidWrite ifidFlush idexWrite idexBubble exmemBubble mdBusy mdDone.
    // left = cycles of the current mul/div still to come after this one has been classified;
    // 0 idle, 1 means this cycle is the done cycle, >1 a freeze cycle.
    function automatic logic [7:0] exp_ctl(input int i);
        bit hz;
        hz = exMemRead && exW[0] && ((idUse1 && idreg1 == exRegDest) || (idUse2 && idreg2 == exRegDest));
        if (!rst_n)          return 8'b1101_0000;
        if (left[i] > 1)     return 8'b0000_0110;
        if (left[i] == 1)    return 8'b1101_0001;
        if (branchTaken)     return 8'b1111_1000;
        if (mdStart)         return 8'b0000_0110;
        if (hz)              return 8'b0001_1000;
        return 8'b1101_0000;
    endfunction

    task automatic check(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                left[i] = 0;
                cnt[i]  = 0;
            end
            e = exp_ctl(i);
            epw[i] = e[7];
            n_cmp++;
            assert (ctl[i] === e) else begin
                n_fail++;
                $error("FAIL %s ctl dut%0d observed=%b expected=%b", tag, i, ctl[i], e);
            end
            n_cmp++;
            assert (sc[i] === 16'(cnt[i])) else begin
                n_fail++;
                $error("FAIL %s stallCount dut%0d observed=%0d expected=%0d", tag, i, sc[i], cnt[i]);
            end
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                left[i] = 0;
                cnt[i]  = 0;
            end else begin
                if (stallClr)                      cnt[i] = 0;
                else if (!epw[i] && cnt[i] < maxc[i]) cnt[i] = cnt[i] + 1;
                if (left[i] > 0)                   left[i] = left[i] - 1;
                else if (!branchTaken && mdStart)  left[i] = lat[i] - 1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic idle();
        idreg1 = 4'd1; idreg2 = 4'd2; idUse1 = 1'b0; idUse2 = 1'b0;
        exRegDest = 4'd0; exW = 2'b00; exMemRead = 1'b0;
        branchTaken = 1'b0; mdStart = 1'b0; stallClr = 1'b0;
    endtask

    task automatic set_load_use();
        exMemRead = 1'b1; exW = 2'b01; exRegDest = 4'd5; idreg2 = 4'd5; idUse2 = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin left[i] = 0; cnt[i] = 0; epw[i] = 1'b1; end
        idle();
        rst_n = 1'b0;
        branchTaken = 1'b1;
        mdStart = 1'b1;
        cycle("reset_forced");
        cycle("reset_forced2");
        idle();
        #1 rst_n = 1'b1;
        cycle("after_reset");

        set_load_use();
        cycle("load_use");
        idle();
        cycle("load_use_gone");
        set_load_use();
        idUse2 = 1'b0;
        cycle("no_use_no_stall");
        idle();

        mdStart = 1'b1;
        for (int k = 0; k < 8; k++) cycle("md_held");
        idle();
        for (int k = 0; k < 3; k++) cycle("md_after");

        set_load_use();
        branchTaken = 1'b1;
        cycle("branch_over_load_use");
        idle();
        mdStart = 1'b1;
        cycle("md_start");
        mdStart = 1'b0;
        branchTaken = 1'b1;
        set_load_use();
        for (int k = 0; k < 8; k++) cycle("branch_in_busy");
        idle();

        mdStart = 1'b1;
        cycle("md_start_r");
        mdStart = 1'b0;
        cycle("freeze2");
        rst_n = 1'b0;
        cycle("reset_mid_op");
        cycle("reset_hold");
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) cycle("no_done_after_reset");

        stallClr = 1'b1;
        cycle("clear");
        stallClr = 1'b0;
        set_load_use();
        for (int k = 0; k < 20; k++) cycle("saturate");
        stallClr = 1'b1;
        cycle("clr_in_stall");
        stallClr = 1'b0;
        cycle("after_clr");
        idle();
        cycle("settle");

        for (int k = 0; k < 400; k++) begin
            idreg1      = 4'($urandom_range(0, 3));
            idreg2      = 4'($urandom_range(0, 3));
            exRegDest   = 4'($urandom_range(0, 3));
            idUse1      = 1'($urandom_range(0, 1));
            idUse2      = 1'($urandom_range(0, 1));
            exW         = 2'($urandom_range(0, 3));
            exMemRead   = 1'($urandom_range(0, 1));
            branchTaken = ($urandom_range(0, 7) == 0);
            mdStart     = ($urandom_range(0, 5) == 0);
            stallClr    = ($urandom_range(0, 31) == 0);
            rst_n       = ($urandom_range(0, 99) != 0);
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hazard sequencer that sits beside forwardingUnit in the ID/EX control path. It detects load-use hazards that forwarding cannot cover and handles taken-branch flushes. It also freezes the front of the pipeline while the multi-cycle multiply/divide unit (implicit R0 writer) is busy. It drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, and keeps a saturating stall-cycle counter.

Parameters:
MD_LATENCY, 8, total EX-stage cycles of a mul/div op including its completion cycle; legal range 2..255.
STALL_CNT_W, 16, width of stallCount.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
idreg1  input  4  ID-stage source register 1.
idreg2  input  4  ID-stage source register 2.
idUse1  input  1  ID instruction actually reads idreg1.
idUse2  input  1  ID instruction actually reads idreg2.
exRegDest  input  4  EX-stage destination register.
exW  input  2  EX write flags: [0] GPR write, [1] implicit R0 write.
exMemRead  input  1  EX instruction is a load.
branchTaken  input  1  branch in EX resolved taken.
mdStart  input  1  EX instruction is a mul/div.
stallClr  input  1  synchronous clear of stallCount.
pcWrite  output  1  PC update enable.
ifidWrite  output  1  IF/ID register enable.
ifidFlush  output  1  IF/ID register cleared to NOP.
idexWrite  output  1  ID/EX register enable.
idexBubble  output  1  ID/EX loaded with NOP.
exmemBubble  output  1  EX/MEM loaded with NOP.
mdBusy  output  1  mul/div in progress, pipeline frozen.
mdDone  output  1  mul/div result valid this cycle.
stallCount  output  STALL_CNT_W  cycles with pcWrite==0, saturating.

Behaviour:
- States: RUN, MD_BUSY. Registered: state, 8-bit mdCnt, stallCount. All other outputs are combinational from state and inputs.
- Defaults (no event): pcWrite=ifidWrite=idexWrite=1; all others 0.
- While rst_n=0: state=RUN, mdCnt=0, stallCount=0. Outputs are forced to the defaults regardless of inputs.
- Reset asserted mid mul/div aborts the op and returns to RUN with no mdDone.
- RUN priority, highest first:
  1) branchTaken: ifidFlush=1, idexBubble=1, pcWrite=1. mdStart and load-use are ignored this cycle.
  2) mdStart: freeze cycle. pcWrite=ifidWrite=idexWrite=0, exmemBubble=1, mdBusy=1. Then mdCnt<=MD_LATENCY-2, state<=MD_BUSY.
  3) Load-use: exMemRead && exW[0] && ((idUse1 && idreg1==exRegDest) || (idUse2 && idreg2==exRegDest)). Response: pcWrite=0, ifidWrite=0, idexBubble=1, for one cycle only. No state change. Next cycle the load is in MEM and forwardingUnit covers it.
- MD_BUSY:
  - mdCnt!=0: freeze outputs as in RUN case 2, mdCnt<=mdCnt-1.
  - mdCnt==0: mdDone=1, default outputs so EX advances with the result, state<=RUN.
  - mdStart, branchTaken and load-use are ignored throughout MD_BUSY, including the done cycle, because the same mul/div is still in EX.
- Timing: freeze lasts exactly MD_LATENCY-1 cycles, starting with the mdStart cycle; mdDone follows in the next cycle. With MD_LATENCY=2: one freeze cycle, then done.
- stallCount:
  - Increments at each clock edge where pcWrite==0.
  - Holds at all-ones (no wrap).
  - stallClr has priority over increment: the count becomes 0 and that cycle's stall is not counted.
- A load-use hazard on the instruction that enters ID during a freeze is evaluated only once state is RUN.

Test Plan:
- Reset: rst_n=0 with branchTaken=1, mdStart=1 -> pcWrite=1, ifidFlush=0, mdBusy=0, stallCount=0. Release -> RUN.
- Load-use: exMemRead=1, exW=01, exRegDest=5, idreg2=5, idUse2=1 for one cycle -> pcWrite=0, ifidWrite=0, idexBubble=1 that cycle only; stallCount=1. Same with idUse2=0 -> no stall.
- Mul/div, MD_LATENCY=8: mdStart held high 8 cycles -> mdBusy=1, idexWrite=0, exmemBubble=1 for 7 cycles; mdDone=1 on cycle 8; stallCount=7. Repeat with MD_LATENCY=2 -> 1 freeze, then done.
- Priority: branchTaken=1 with a load-use match -> ifidFlush=1, idexBubble=1, pcWrite=1, stallCount unchanged. branchTaken=1 during MD_BUSY -> ignored.
- Reset mid-op: drop rst_n at freeze cycle 3 -> immediately mdBusy=0, pcWrite=1; after release, no mdDone.
- Counter: force STALL_CNT_W=4, run 20 stall cycles -> stallCount=15 held. stallClr=1 during a stall -> 0 next edge.
